// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch flush, data-memory freeze and busy watchdog.
// Define HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
  parameter int WDOG_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rt,
  input  logic       ex_beq,
  input  logic       ex_bne,
  input  logic       ex_zero,
  input  logic       dmem_busy,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pipe_freeze,
  output logic       wdog_err,
  output logic [1:0] state
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] BUBBLE   = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [7:0] WDOG_LIM = WDOG_MAX[7:0];

  logic [1:0] state_q, state_d;
  logic [7:0] busy_cnt_q, busy_cnt_d;
  logic       wdog_err_q, wdog_err_d;
  logic       br_taken, lu_hit, lu_act;

  assign br_taken = (ex_beq & ex_zero) | (ex_bne & ~ex_zero);
  assign lu_hit   = ex_MemRead & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  // BUBBLE masks the hazard so one load-use costs exactly one slot.
  assign lu_act   = lu_hit & (state_q != BUBBLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // MEM_WAIT with memory ready, and the unused encoding, both behave as RUN.
  always_comb begin
    state_d = RUN;
    if (state_q == 2'd3)  state_d = RUN;
    else if (dmem_busy)   state_d = MEM_WAIT;
    else if (br_taken)    state_d = RUN;
    else if (lu_act)      state_d = BUBBLE;
    else                  state_d = RUN;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (rst_n) begin
      if (dmem_busy) begin
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
      end else if (br_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (lu_act) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_flush  = 1'b1;
      end else begin
        ifid_flush  = id_jump;
      end
    end
  end

  always_comb begin
    busy_cnt_d = 8'd0;
    if (dmem_busy) busy_cnt_d = (busy_cnt_q == 8'hFF) ? busy_cnt_q : busy_cnt_q + 8'd1;
    wdog_err_d = wdog_err_q | (dmem_busy & (busy_cnt_d == WDOG_LIM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_q <= 8'd0;
      wdog_err_q <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
  assign state    = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if ((idex_flush || ifid_flush) && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl plus reset, watchdog and perf-counter sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 0, id_jump = 0, ex_MemRead = 0;
  logic       ex_beq = 0, ex_bne = 0, ex_zero = 0, dmem_busy = 0;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, wdog_err;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.WDOG_MAX(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_zero(ex_zero), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_freeze(pipe_freeze), .wdog_err(wdog_err), .state(state)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // exp packs {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, state[1:0]}
  typedef struct {
    logic [4:0] rs, rt;
    logic       ut, jmp, mr;
    logic [4:0] ert;
    logic       beq, bne, zero, busy;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic ut, logic jmp, logic mr,
                              logic [4:0] ert, logic beq, logic bne, logic zero, logic busy,
                              logic [6:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ut = ut; v.jmp = jmp; v.mr = mr; v.ert = ert;
    v.beq = beq; v.bne = bne; v.zero = zero; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ut; id_jump = v.jmp;
    ex_MemRead = v.mr; ex_rt = v.ert; ex_beq = v.beq; ex_bne = v.bne;
    ex_zero = v.zero; dmem_busy = v.busy;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  function automatic logic [6:0] outs();
    return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, state};
  endfunction

  initial begin
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000); // idle
    vt[1]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7'b1110000); // jump
    vt[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 7'b1100000); // $zero exempt
    vt[3]  = mk(5, 0, 0, 0, 1, 5, 0, 0, 0, 0, 7'b0001000); // load-use on rs
    vt[4]  = mk(5, 0, 0, 0, 1, 5, 0, 0, 0, 0, 7'b1100001); // bubble masks lu_hit
    vt[5]  = mk(3, 7, 0, 0, 1, 7, 0, 0, 0, 0, 7'b1100000); // rt match, rt unused
    vt[6]  = mk(3, 7, 1, 0, 1, 7, 0, 0, 0, 0, 7'b0001000); // rt match, rt used
    vt[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 7'b1110001); // jump in bubble
    vt[8]  = mk(5, 0, 0, 1, 1, 5, 1, 0, 1, 0, 7'b1111000); // branch beats lu/jump
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b1100000); // bne not taken
    vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1111000); // bne taken
    vt[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'b1100000); // beq not taken
    vt[12] = mk(5, 0, 0, 0, 1, 5, 1, 0, 1, 1, 7'b0000100); // freeze beats all
    vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0000110);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0000110);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100010); // ready: acts as RUN
    vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000);
    vt[17] = mk(5, 0, 0, 0, 1, 5, 0, 0, 0, 0, 7'b0001000);
    vt[18] = mk(5, 0, 0, 0, 1, 5, 0, 0, 0, 1, 7'b0000101); // busy in bubble
    vt[19] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 7'b1111010); // branch leaving wait
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100000);

    // reset with hostile inputs
    drive(mk(5, 0, 0, 1, 1, 5, 1, 0, 1, 1, 7'b0));
    #2;
    chk("reset_outs", 32'(outs()), 32'(7'b1100000));
    chk("reset_wdog", 32'(wdog_err), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("reset_perf", {stall_cnt, flush_cnt}, 32'd0);
`endif
    do_reset();

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
    end
`ifdef HAZARD_PERF_EN
    chk("table_stall_cnt", 32'(stall_cnt), 32'd7);
    chk("table_flush_cnt", 32'(flush_cnt), 32'd8);
`endif

    // reset mid-bubble discards the pending bubble
    do_reset();
    @(negedge clk);
    drive(mk(5, 0, 0, 0, 1, 5, 0, 0, 0, 0, 7'b0));
    @(posedge clk); #2;
    chk("pre_rst_bubble", 32'(state), 32'd1);
    rst_n = 1'b0;
    dmem_busy = 1'b1;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'(7'b1100000));
    @(negedge clk);
    dmem_busy = 1'b0;
    rst_n = 1'b1;
    #2;
    chk("post_rst_lu_stall", 32'(outs()), 32'(7'b0001000));

    // reset mid-MEM_WAIT
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0));
    @(posedge clk); #2;
    chk("pre_rst_memwait", 32'(state), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_memwait_state", 32'(state), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_run", 32'(outs()), 32'(7'b1100000));

    // watchdog: trips exactly on the 255th consecutive busy cycle
    do_reset();
    @(negedge clk);
    dmem_busy = 1'b1;
    repeat (254) @(posedge clk);
    #2;
    chk("wdog_254", 32'(wdog_err), 32'd0);
    @(posedge clk); #2;
    chk("wdog_255", 32'(wdog_err), 32'd1);
    @(negedge clk);
    dmem_busy = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("wdog_sticky", 32'(wdog_err), 32'd1);
    chk("wdog_state_run", 32'(state), 32'd0);
    do_reset();
    #1;
    chk("wdog_cleared", 32'(wdog_err), 32'd0);

    // busy burst shorter than limit, then a fresh run of 254 does not trip
    @(negedge clk);
    dmem_busy = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    dmem_busy = 1'b0;
    @(negedge clk);
    dmem_busy = 1'b1;
    repeat (254) @(posedge clk);
    #2;
    chk("wdog_cleared_count", 32'(wdog_err), 32'd0);
    @(negedge clk);
    dmem_busy = 1'b0;

`ifdef HAZARD_PERF_EN
    // two load-use hazards and one taken bne
    do_reset();
    @(negedge clk); drive(mk(5, 0, 0, 0, 1, 5, 0, 0, 0, 0, 7'b0));
    @(negedge clk); idle();
    @(negedge clk); drive(mk(0, 9, 1, 0, 1, 9, 0, 0, 0, 0, 7'b0));
    @(negedge clk); idle();
    @(negedge clk); drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0));
    @(negedge clk); idle();
    #2;
    chk("perf_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("perf_flush_cnt", 32'(flush_cnt), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 255, meaning the number of consecutive dmem_busy cycles tolerated before wdog_err is set.
REQ-002 SHALL have these ports, in order: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have: id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
REQ-005 SHALL have: id_uses_rt  in  1  ID instruction reads rt.
REQ-006 SHALL have: id_jump  in  1  ID instruction is a jump.
REQ-007 SHALL have: ex_MemRead  in  1  MemRead control bit held in the ID/EX register.
REQ-008 SHALL have: ex_rt  in  5  destination rt held in the ID/EX register.
REQ-009 SHALL have: ex_beq, ex_bne, ex_zero  in  1 each  EX-stage branch controls and ALU zero flag.
REQ-010 SHALL have: dmem_busy  in  1  data memory not ready.
REQ-011 SHALL have outputs pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze (1 each), wdog_err (1), state (2).

Function
REQ-012 SHALL implement FSM states RUN=0, BUBBLE=1, MEM_WAIT=2; encoding 3 is unreachable and returns to RUN on the next edge.
REQ-013 SHALL define br_taken = (ex_beq & ex_zero) | (ex_bne & ~ex_zero).
REQ-014 SHALL define lu_hit = ex_MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
REQ-015 SHALL, in RUN or BUBBLE with dmem_busy=1, drive pipe_freeze=1, pc_write=0, ifid_write=0, and both flushes=0, then go to MEM_WAIT; this has top priority.
REQ-016 SHALL, in MEM_WAIT, hold these same outputs while dmem_busy=1, and return to RUN on the first edge with dmem_busy=0; the output logic evaluates that cycle as RUN.
REQ-017 SHALL, with no freeze and br_taken=1, drive ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1; the next state is RUN, and lu_hit and id_jump are ignored.
REQ-018 SHALL, in RUN with no freeze, br_taken=0 and lu_hit=1, drive pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0, then go to BUBBLE.
REQ-019 SHALL mask lu_hit in BUBBLE, so each load-use hazard inserts exactly one bubble.
REQ-020 SHALL, with no freeze, br_taken=0 and no active lu_hit, drive ifid_flush=id_jump, pc_write=1, ifid_write=1, idex_flush=0.
REQ-021 SHALL compute all outputs except state and wdog_err combinationally from the current state and inputs, giving zero-cycle latency to the pipeline registers.
REQ-022 SHALL count consecutive cycles with dmem_busy=1 in an 8-bit saturating counter, cleared when dmem_busy=0.
REQ-023 SHALL set wdog_err sticky on the edge where the counter reaches WDOG_MAX; only reset clears it.

Reset
REQ-024 SHALL asynchronously set state=RUN, wdog_err=0, the busy counter=0 and all perf counters=0 while rst_n=0.
REQ-025 SHALL hold outputs during reset at pc_write=1, ifid_write=1, both flushes=0 and pipe_freeze=0, regardless of inputs.
REQ-026 SHALL discard any pending BUBBLE or MEM_WAIT on reset assertion mid-operation; the first active edge after release starts in RUN.

Configuration
REQ-027 SHALL, when macro HAZARD_PERF_EN is defined, add outputs stall_cnt[15:0] and flush_cnt[15:0].
REQ-028 SHALL increment stall_cnt each cycle pc_write=0, saturating at 0xFFFF.
REQ-029 SHALL increment flush_cnt each cycle idex_flush=1 or ifid_flush=1, saturating at 0xFFFF.
REQ-030 SHALL, without HAZARD_PERF_EN, omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover load-use: ex_MemRead=1, ex_rt=5, id_rs=5 -> one cycle of pc_write=0 and idex_flush=1, state=BUBBLE, then pc_write=1 with lu_hit still 1.
REQ-032 SHALL cover the $zero exemption: ex_MemRead=1, ex_rt=0, id_rs=0 -> no stall, state stays RUN.
REQ-033 SHALL cover branch priority: ex_beq=1, ex_zero=1 and lu_hit=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1, next state RUN.
REQ-034 SHALL cover memory wait: dmem_busy=1 for 3 cycles -> pipe_freeze=1 for 3 cycles with state=MEM_WAIT; after dmem_busy drops, the next cycle behaves as RUN.
REQ-035 SHALL cover the watchdog: dmem_busy=1 for 255 cycles -> wdog_err=1, which stays 1 after dmem_busy=0 until rst_n pulses low.
REQ-036 SHALL cover perf counters with HAZARD_PERF_EN defined: 2 load-use hazards plus 1 taken bne -> stall_cnt=2, flush_cnt=3.
